// File: rtl/dfs_lut_writer.sv
// DFS lookup-table writer: single writes and inclusive range fills
// into a BRAM port, with abort and bad-range rejection.
module dfs_lut_writer #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 18,
  parameter int WE_WIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_fill_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_end_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_data_i,
  input  logic                  abort_i,
  output logic                  mem_en_o,
  output logic [WE_WIDTH-1:0]   mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FILL,
    ERR
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] end_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic accept;
  logic last;
  logic ready;
  logic en;
  logic done;
  logic err;

  assign accept = cmd_valid_i & cmd_ready_o;
  assign last   = (cnt_q == end_q);

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    en      = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (accept) begin
          if (!cmd_fill_i)
            state_d = WRITE;
          else if (cmd_end_addr_i >= cmd_addr_i)
            state_d = FILL;
          else
            state_d = ERR;
        end
      end
      WRITE: begin
        en      = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      FILL: begin
        if (abort_i) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          en = 1'b1;
          if (last) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      ERR: begin
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter stops on the end address, so a fill ending at the top never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      end_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept && state_d != ERR) begin
        cnt_q  <= cmd_addr_i;
        end_q  <= cmd_fill_i ? cmd_end_addr_i : cmd_addr_i;
        data_q <= cmd_data_i;
      end else if (state_q == FILL && !abort_i && !last) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Reset kills any write or pulse in the cycle it is asserted.
  assign cmd_ready_o = ready & ~reset;
  assign mem_en_o    = en & ~reset;
  assign mem_we_o    = {WE_WIDTH{mem_en_o}};
  assign mem_addr_o  = cnt_q;
  assign mem_data_o  = data_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done & ~reset;
  assign err_o       = err & ~reset;

endmodule
